pio_pulse_sequencer: RTL
========================

PIO_PULSE_SEQUENCER -- requirements
Module: pio_pulse_sequencer

Interface
REQ-001 Parameter CNT_W, default 16: width of the on/off interval fields and the interval timer.
REQ-002 Parameter REP_W, default 8: width of the repeat-count field and the remaining-pulse counter.
REQ-003 clk  in  1  single clock; all logic is on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  command strobe; sampled only in IDLE.
REQ-006 on_cycles  in  CNT_W  high interval, in clocks; sampled with start.
REQ-007 off_cycles  in  CNT_W  low interval, in clocks; sampled with start.
REQ-008 repeat_count  in  REP_W  number of pulses; sampled with start.
REQ-009 abort  in  1  terminates an active sequence.
REQ-010 busy  out  1  high while a sequence is active.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 m_address  out  2  Avalon-MM master address to the PIO slave; constant 0.
REQ-013 m_chipselect  out  1  write strobe qualifier.
REQ-014 m_write_n  out  1  active-low write.
REQ-015 m_writedata  out  32  bit0 carries the level; bits 31:1 are always 0.

Function
REQ-016 The block SHALL be an FSM with states IDLE, WR_ON, ON_WAIT, WR_OFF, OFF_WAIT, ABORT_WR and DONE; all outputs are registered.
REQ-017 Write strobe: in WR_ON, WR_OFF and ABORT_WR only, for exactly one cycle, the block SHALL drive m_chipselect=1, m_write_n=0 and m_address=0.
- WR_ON: m_writedata=1.
- WR_OFF and ABORT_WR: m_writedata=0.
- No waitrequest; every strobe is accepted in that cycle.
REQ-018 Start in IDLE with repeat_count!=0:
- latch on_cycles, off_cycles and repeat_count;
- enter WR_ON on the next cycle.
REQ-019 Effective interval N = max(field, 1). The spacing between the WR_ON strobe and the following WR_OFF strobe SHALL be exactly N_on cycles; ON_WAIT lasts N_on-1 cycles and is skipped when N_on=1.
REQ-020 WR_OFF:
- decrement the remaining-pulse count;
- if that pulse was the last, go to DONE;
- otherwise go to OFF_WAIT, so that the next WR_ON strobe follows exactly N_off cycles later (OFF_WAIT is skipped when N_off=1).
REQ-021 busy SHALL be 1 in WR_ON, ON_WAIT, WR_OFF, OFF_WAIT and ABORT_WR, and 0 in IDLE and DONE.
REQ-022 DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-023 start while not in IDLE SHALL be ignored; latched parameters SHALL NOT change while busy.
REQ-024 abort in WR_ON, ON_WAIT, WR_OFF or OFF_WAIT SHALL go to ABORT_WR, then DONE.
- Abort coincident with a WR_OFF strobe still issues the ABORT_WR strobe.
- abort in IDLE or DONE is ignored.
- start and abort together in IDLE: start is accepted.
REQ-025 start in IDLE with repeat_count=0 SHALL go directly to DONE with no strobe, unless PIO_SEQ_CONTINUOUS_EN is defined (REQ-029).

Reset
REQ-026 While reset_n=0, the block SHALL immediately and asynchronously force:
- state IDLE; busy=0; done=0;
- m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0;
- timer and counter cleared.
REQ-027 Reset mid-sequence SHALL abandon the sequence without issuing a strobe; the PIO shares reset_n and clears itself.
REQ-028 The first start SHALL be accepted on the first rising edge with reset_n=1.

Configuration
REQ-029 Macro PIO_SEQ_CONTINUOUS_EN:
- Defined: repeat_count=0 runs ON/OFF pulses indefinitely, with the remaining-pulse counter not decremented; it ends only via abort (ABORT_WR, then DONE).
- Undefined: REQ-025 applies and no continuous-mode logic is built.

Verification
REQ-030 on=3, off=2, repeat=2, start at c0 -> strobes: 1@c1, 0@c4, 1@c6, 0@c9; done@c10; busy c1-c9; exactly 4 strobes.
REQ-031 on=0, off=0, repeat=1 -> strobes: 1@c1, 0@c2; done@c3.
REQ-032 repeat=0, macro undefined -> no strobe, done@c1. Macro defined -> pulses continue for more than 1000 cycles; abort then yields a 0-strobe followed by done.
REQ-033 on=10, repeat=3, abort@c5 (ON_WAIT) -> 0-strobe@c6, done@c7; start@c3 is ignored and the latched values are unchanged.
REQ-034 reset_n low @c5 of REQ-030 stimulus -> outputs at reset values within the same cycle, no further strobes; a new start after release reproduces the REQ-030 timing.

Source files
------------

// File: rtl/pio_pulse_sequencer.sv
// Drives a PIO output through an Avalon-MM master as a train of on/off pulses.
// Optional build macro PIO_SEQ_CONTINUOUS_EN: repeat_count=0 pulses until abort.
module pio_pulse_sequencer #(
  parameter int CNT_W = 16,
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] on_cycles,
  input  logic [CNT_W-1:0] off_cycles,
  input  logic [REP_W-1:0] repeat_count,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [1:0]       m_address,
  output logic             m_chipselect,
  output logic             m_write_n,
  output logic [31:0]      m_writedata
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ON, S_ON_WAIT, S_WR_OFF, S_OFF_WAIT, S_ABORT_WR, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] on_q, on_d, off_q, off_d, timer_q, timer_d;
  logic [REP_W-1:0] rem_q, rem_d;
  logic             busy_q, done_q, cs_q, wr_n_q, wd_q;
  logic             strobe_d;

  always_comb begin
    // NOTE: every signal written here takes a default first, so no path through the case infers a latch.
    state_d = state_q;
    on_d    = on_q;
    off_d   = off_q;
    timer_d = timer_q;
    rem_d   = rem_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          on_d  = on_cycles;
          off_d = off_cycles;
          rem_d = repeat_count;
`ifdef PIO_SEQ_CONTINUOUS_EN
          state_d = S_WR_ON;
`else
          state_d = (repeat_count == '0) ? S_DONE : S_WR_ON;
`endif
        end
      end
      // The write cycle itself counts as one clock of the interval, hence the -2 preload.
      S_WR_ON: begin
        if (abort) begin
          state_d = S_ABORT_WR;
        end else if (on_q <= CNT_W'(1)) begin
          state_d = S_WR_OFF;
        end else begin
          timer_d = on_q - CNT_W'(2);
          state_d = S_ON_WAIT;
        end
      end
      S_ON_WAIT: begin
        if (abort)                 state_d = S_ABORT_WR;
        else if (timer_q == '0)    state_d = S_WR_OFF;
        else                       timer_d = timer_q - CNT_W'(1);
      end
      S_WR_OFF: begin
        if (abort) begin
          state_d = S_ABORT_WR;
        end else if (rem_q == REP_W'(1)) begin
          rem_d   = '0;
          state_d = S_DONE;
        end else begin
`ifdef PIO_SEQ_CONTINUOUS_EN
          if (rem_q != '0) rem_d = rem_q - REP_W'(1);
`else
          rem_d = rem_q - REP_W'(1);
`endif
          if (off_q <= CNT_W'(1)) begin
            state_d = S_WR_ON;
          end else begin
            timer_d = off_q - CNT_W'(2);
            state_d = S_OFF_WAIT;
          end
        end
      end
      S_OFF_WAIT: begin
        if (abort)                 state_d = S_ABORT_WR;
        else if (timer_q == '0)    state_d = S_WR_ON;
        else                       timer_d = timer_q - CNT_W'(1);
      end
      S_ABORT_WR: state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  assign strobe_d = (state_d == S_WR_ON) || (state_d == S_WR_OFF) || (state_d == S_ABORT_WR);

  // Outputs are decoded from the next state and registered alongside it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the latched interval fields are reset too, so nothing in the block is ever undefined after reset.
      state_q <= S_IDLE;
      on_q    <= '0;
      off_q   <= '0;
      timer_q <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b0;
      wr_n_q  <= 1'b1;
      wd_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      on_q    <= on_d;
      off_q   <= off_d;
      timer_q <= timer_d;
      rem_q   <= rem_d;
      busy_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q  <= (state_d == S_DONE);
      cs_q    <= strobe_d;
      wr_n_q  <= !strobe_d;
      wd_q    <= (state_d == S_WR_ON);
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign m_address    = 2'b00;
  assign m_chipselect = cs_q;
  assign m_write_n    = wr_n_q;
  assign m_writedata  = {31'b0, wd_q};

endmodule
